// File: rtl/adc_sample_assembler.sv
// adc_sample_assembler: frames ADC nibbles into samples and buffers them in a FIFO with overflow tracking.
module adc_sample_assembler #(
    parameter int NIBBLES = 3,
    parameter int DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           nib_in,
    input  logic                 nib_rdy,
    input  logic                 sync,
    output logic [4*NIBBLES-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 ovf,
    output logic [7:0]           drop_cnt,
    input  logic                 clr_ovf
);
    localparam int W  = 4 * NIBBLES;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = $clog2(NIBBLES + 1);

    typedef enum logic {WAIT_SYNC, COLLECT} state_t;

    state_t        r_state;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;

    logic          w_take;
    logic          w_last;
    logic          w_pop;
    logic          w_full;
    logic          w_wr_en;
    logic          w_drop;
    logic [IW-1:0] w_idx;
    logic [W-1:0]  w_acc;

    // sync restarts the frame in the same cycle, so its nibble becomes nibble 0
    always_comb begin
        w_take  = nib_rdy && (sync || r_state == COLLECT);
        w_idx   = sync ? '0 : r_idx;
        w_acc   = ((sync ? '0 : r_acc) << 4) | W'(nib_in);
        w_last  = w_take && (w_idx == IW'(NIBBLES - 1));
        w_pop   = out_valid && out_ready;
        w_full  = r_cnt == (AW+1)'(DEPTH);
        w_wr_en = w_last && (!w_full || w_pop);
        w_drop  = w_last && w_full && !w_pop;
    end

    assign out_valid = r_cnt != '0;
    assign out_data  = out_valid ? r_mem[r_rd] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WAIT_SYNC;
            r_idx   <= '0;
            r_acc   <= '0;
        end else if (sync || w_take) begin
            r_state <= COLLECT;
            r_idx   <= (w_take && !w_last) ? IW'(w_idx + 1'b1) : '0;
            r_acc   <= (w_take && !w_last) ? w_acc : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr] <= w_acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr_en)
                r_wr <= r_wr + 1'b1;
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_wr_en) - (AW+1)'(w_pop);
        end
    end

    // a drop coinciding with a clear counts as the first drop after the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (clr_ovf) begin
            ovf      <= w_drop;
            drop_cnt <= {7'd0, w_drop};
        end else if (w_drop) begin
            ovf      <= 1'b1;
            drop_cnt <= (drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_adc_sample_assembler.sv
// tb_adc_sample_assembler: directed vector table plus multi-cycle corner sequences.
module tb_adc_sample_assembler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  nib_in = '0;
    logic        nib_rdy = 1'b0;
    logic        sync = 1'b0;
    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        ovf;
    logic [7:0]  drop_cnt;
    logic        clr_ovf = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        s;
        logic        r;
        logic [3:0]  n;
        logic        rdy;
        logic        ev;
        logic [11:0] ed;
    } vec_t;

    vec_t tbl [16];

    adc_sample_assembler #(.NIBBLES(3), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .nib_in(nib_in), .nib_rdy(nib_rdy), .sync(sync),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ovf(ovf), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic r, input logic [3:0] n);
        sync = s;
        nib_rdy = r;
        nib_in = n;
        @(posedge clk);
        #1;
        sync = 1'b0;
        nib_rdy = 1'b0;
        nib_in = '0;
    endtask

    task automatic push(input logic [11:0] v);
        step(1'b0, 1'b1, v[11:8]);
        step(1'b0, 1'b1, v[7:4]);
        step(1'b0, 1'b1, v[3:0]);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 12'h000};
        tbl[1]  = '{1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 12'h000};
        tbl[2]  = '{1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 12'h000};
        tbl[3]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 12'h000};
        tbl[4]  = '{1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 12'h000};
        tbl[5]  = '{1'b0, 1'b1, 4'hB, 1'b1, 1'b0, 12'h000};
        tbl[6]  = '{1'b0, 1'b1, 4'hC, 1'b1, 1'b1, 12'hABC};
        tbl[7]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h000};
        tbl[8]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 12'h000};
        tbl[9]  = '{1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 12'h000};
        tbl[10] = '{1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 12'h000};
        tbl[11] = '{1'b1, 1'b1, 4'h7, 1'b1, 1'b0, 12'h000};
        tbl[12] = '{1'b0, 1'b1, 4'h8, 1'b1, 1'b0, 12'h000};
        tbl[13] = '{1'b0, 1'b1, 4'h9, 1'b1, 1'b1, 12'h789};
        tbl[14] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 12'h789};
        tbl[15] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h000};

        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h0);
        rst = 1'b0;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_data", 32'(out_data), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        chk("reset_drop", 32'(drop_cnt), 32'd0);

        // assembly, wait-for-sync, resync and hold-while-stalled
        for (int i = 0; i < 16; i++) begin
            out_ready = tbl[i].rdy;
            step(tbl[i].s, tbl[i].r, tbl[i].n);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
        end

        // overflow: fifth sample dropped, first four drained in order
        out_ready = 1'b0;
        step(1'b1, 1'b0, 4'h0);
        for (int k = 1; k <= 5; k++) push(12'(k));
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_drop1", 32'(drop_cnt), 32'd1);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ovf_drain%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("ovf_drain%0d_data", k), 32'(out_data), 32'(k));
            step(1'b0, 1'b0, 4'h0);
        end
        chk("ovf_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        clr_ovf = 1'b1;
        step(1'b0, 1'b0, 4'h0);
        clr_ovf = 1'b0;
        chk("clr_ovf", 32'(ovf), 32'd0);
        chk("clr_drop", 32'(drop_cnt), 32'd0);

        // full FIFO with push and pop in the same cycle
        for (int k = 1; k <= 4; k++) push(12'h100 + 12'(k));
        step(1'b0, 1'b1, 4'h1);
        step(1'b0, 1'b1, 4'h0);
        out_ready = 1'b1;
        step(1'b0, 1'b1, 4'h5);
        out_ready = 1'b0;
        chk("pp_ovf", 32'(ovf), 32'd0);
        chk("pp_drop", 32'(drop_cnt), 32'd0);
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("pp_drain%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("pp_drain%0d_data", k), 32'(out_data), 32'h100 + 32'(k));
            step(1'b0, 1'b0, 4'h0);
        end
        chk("pp_empty", 32'(out_valid), 32'd0);

        // saturation, clear racing a drop, then contents intact
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) push(12'h200 + 12'(k));
        for (int i = 0; i < 300; i++) push(12'h3FF);
        chk("sat_drop", 32'(drop_cnt), 32'd255);
        chk("sat_ovf", 32'(ovf), 32'd1);
        step(1'b0, 1'b1, 4'h3);
        step(1'b0, 1'b1, 4'hF);
        clr_ovf = 1'b1;
        step(1'b0, 1'b1, 4'hF);
        clr_ovf = 1'b0;
        chk("clrdrop_ovf", 32'(ovf), 32'd1);
        chk("clrdrop_cnt", 32'(drop_cnt), 32'd1);
        clr_ovf = 1'b1;
        step(1'b0, 1'b0, 4'h0);
        clr_ovf = 1'b0;
        chk("clr2_ovf", 32'(ovf), 32'd0);
        chk("clr2_cnt", 32'(drop_cnt), 32'd0);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("sat_drain%0d_data", k), 32'(out_data), 32'h200 + 32'(k));
            step(1'b0, 1'b0, 4'h0);
        end
        chk("sat_empty", 32'(out_valid), 32'd0);

        // reset mid-frame beats a simultaneous sync+nibble; later nibbles ignored
        step(1'b1, 1'b0, 4'h0);
        step(1'b0, 1'b1, 4'h1);
        step(1'b0, 1'b1, 4'h2);
        rst = 1'b1;
        step(1'b1, 1'b1, 4'h3);
        rst = 1'b0;
        chk("rstmid_valid", 32'(out_valid), 32'd0);
        chk("rstmid_data", 32'(out_data), 32'd0);
        for (int k = 3; k <= 5; k++) begin
            step(1'b0, 1'b1, 4'(k));
            chk($sformatf("rstmid_nib%0d_valid", k), 32'(out_valid), 32'd0);
        end
        step(1'b0, 1'b0, 4'h0);
        chk("rstmid_idle_valid", 32'(out_valid), 32'd0);
        step(1'b1, 1'b0, 4'h0);
        push(12'h6AB);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_data", 32'(out_data), 32'h6AB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
